// File: rtl/mda_crtc_regs.sv
// MDA CRTC CPU front end: 6845 index/data file, mode latch and status port at 03B0h-03BFh.
// Define MDA_CRTC_FULL_READBACK_EN to make R0-R13 readable through the data port.
module mda_crtc_regs #(
    parameter logic [15:0] IO_BASE = 16'h03B0
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [15:0] iIoAddr,
    input  logic [7:0]  iIoData,
    input  logic        iIoWr,
    input  logic        iIoRd,
    output logic [7:0]  oIoData,
    output logic        oIoSel,
    input  logic        iVgaBlank,
    input  logic        iVgaVs,
    output logic [13:0] oStartAddr,
    output logic [13:0] oCursorAddr,
    output logic [4:0]  oCursorStart,
    output logic [4:0]  oCursorEnd,
    output logic        oCursorOn,
    output logic        oCharBlink,
    output logic        oVideoEn,
    output logic        oBlinkEn
);

    function automatic logic [7:0] reg_mask(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd2, 4'd3: reg_mask = 8'hFF;
            4'd4, 4'd6, 4'd7:       reg_mask = 8'h7F;
            4'd5, 4'd9, 4'd11:      reg_mask = 8'h1F;
            4'd8:                   reg_mask = 8'h03;
            4'd10:                  reg_mask = 8'h7F;
            4'd12, 4'd14:           reg_mask = 8'h3F;
            default:                reg_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] reg_reset(input logic [3:0] i);
        case (i)
            4'd0:    reg_reset = 8'h61;
            4'd1:    reg_reset = 8'h50;
            4'd2:    reg_reset = 8'h52;
            4'd3:    reg_reset = 8'h0F;
            4'd4:    reg_reset = 8'h19;
            4'd5:    reg_reset = 8'h06;
            4'd6:    reg_reset = 8'h19;
            4'd7:    reg_reset = 8'h19;
            4'd8:    reg_reset = 8'h02;
            4'd9:    reg_reset = 8'h0D;
            4'd10:   reg_reset = 8'h0B;
            4'd11:   reg_reset = 8'h0C;
            default: reg_reset = 8'h00;
        endcase
    endfunction

    // R16/R17 (light pen) are not stored: they always read as zero.
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [4:0] idx_q, idx_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] io_data_q, io_data_d;
    logic       io_sel_q, io_sel_d;
    logic [4:0] frame_q, frame_d;
    logic       blank_s1_q, blank_s2_q;
    logic       vs_s1_q, vs_s2_q, vs_s3_q;

    logic       hit;
    logic [3:0] off;
    logic       wr_hit;
    logic       rd_hit;
    logic [7:0] data_rd;
    logic [7:0] rd_data;

    assign hit    = (iIoAddr[15:4] == IO_BASE[15:4]);
    assign off    = iIoAddr[3:0];
    assign wr_hit = hit & iIoWr;
    assign rd_hit = hit & iIoRd & ~iIoWr;

    always_comb begin
        data_rd = 8'h00;
`ifdef MDA_CRTC_FULL_READBACK_EN
        if (idx_q < 5'd16)
            data_rd = regs_q[idx_q[3:0]];
`else
        if (idx_q == 5'd14 || idx_q == 5'd15)
            data_rd = regs_q[idx_q[3:0]];
`endif
    end

    always_comb begin
        rd_data = 8'hFF;
        if (!off[3] && off[0])
            rd_data = data_rd;
        else if (off == 4'hA)
            rd_data = {4'hF, vs_s2_q, 2'b00, blank_s2_q};
    end

    always_comb begin
        regs_d    = regs_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        io_data_d = io_data_q;
        io_sel_d  = rd_hit;
        frame_d   = frame_q + {4'd0, vs_s2_q & ~vs_s3_q};
        if (wr_hit) begin
            if (!off[3]) begin
                if (!off[0])
                    idx_d = iIoData[4:0];
                else if (idx_q < 5'd16)
                    regs_d[idx_q[3:0]] = iIoData & reg_mask(idx_q[3:0]);
            end else if (off == 4'h8) begin
                mode_d = iIoData;
            end
        end
        if (rd_hit)
            io_data_d = rd_data;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < 16; i++)
                regs_q[i] <= reg_reset(4'(i));
            idx_q      <= 5'd0;
            mode_q     <= 8'h00;
            io_data_q  <= 8'h00;
            io_sel_q   <= 1'b0;
            frame_q    <= 5'd0;
            blank_s1_q <= 1'b0;
            blank_s2_q <= 1'b0;
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            vs_s3_q    <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            io_data_q  <= io_data_d;
            io_sel_q   <= io_sel_d;
            frame_q    <= frame_d;
            blank_s1_q <= iVgaBlank;
            blank_s2_q <= blank_s1_q;
            vs_s1_q    <= iVgaVs;
            vs_s2_q    <= vs_s1_q;
            vs_s3_q    <= vs_s2_q;
        end
    end

    always_comb begin
        case (regs_q[10][6:5])
            2'b00:   oCursorOn = 1'b1;
            2'b01:   oCursorOn = 1'b0;
            2'b10:   oCursorOn = frame_q[3];
            default: oCursorOn = frame_q[4];
        endcase
    end

    assign oIoData      = io_data_q;
    assign oIoSel       = io_sel_q;
    assign oStartAddr   = {regs_q[12][5:0], regs_q[13]};
    assign oCursorAddr  = {regs_q[14][5:0], regs_q[15]};
    assign oCursorStart = regs_q[10][4:0];
    assign oCursorEnd   = regs_q[11][4:0];
    assign oCharBlink   = frame_q[4];
    assign oVideoEn     = mode_q[3];
    assign oBlinkEn     = mode_q[5];

endmodule

// File: tb/tb_mda_crtc_regs.sv
// Randomized bench for mda_crtc_regs against a register-file model built from widths and reset values.
module tb_mda_crtc_regs;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic [15:0] iIoAddr;
    logic [7:0]  iIoData;
    logic        iIoWr;
    logic        iIoRd;
    logic [7:0]  oIoData;
    logic        oIoSel;
    logic        iVgaBlank;
    logic        iVgaVs;
    logic [13:0] oStartAddr;
    logic [13:0] oCursorAddr;
    logic [4:0]  oCursorStart;
    logic [4:0]  oCursorEnd;
    logic        oCursorOn;
    logic        oCharBlink;
    logic        oVideoEn;
    logic        oBlinkEn;

    mda_crtc_regs dut (
        .iClk(iClk), .iRstN(iRstN), .iIoAddr(iIoAddr), .iIoData(iIoData),
        .iIoWr(iIoWr), .iIoRd(iIoRd), .oIoData(oIoData), .oIoSel(oIoSel),
        .iVgaBlank(iVgaBlank), .iVgaVs(iVgaVs), .oStartAddr(oStartAddr),
        .oCursorAddr(oCursorAddr), .oCursorStart(oCursorStart), .oCursorEnd(oCursorEnd),
        .oCursorOn(oCursorOn), .oCharBlink(oCharBlink), .oVideoEn(oVideoEn), .oBlinkEn(oBlinkEn)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    int wid   [18] = '{8, 8, 8, 8, 7, 5, 7, 7, 2, 5, 7, 5, 6, 8, 6, 8, 6, 8};
    int rstv  [18] = '{'h61, 'h50, 'h52, 'h0F, 'h19, 'h06, 'h19, 'h19, 'h02, 'h0D, 'h0B, 'h0C, 0, 0, 0, 0, 0, 0};
    int mdl_r [18];
    int mdl_idx, mdl_mode, mdl_frame, exp_data, exp_sel;
    int cur_blank, cur_vs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < 18; i++) mdl_r[i] = rstv[i];
        mdl_idx = 0; mdl_mode = 0; mdl_frame = 0; exp_data = 0; exp_sel = 0;
    endfunction

    function automatic int data_read(input int idx);
`ifdef MDA_CRTC_FULL_READBACK_EN
        return (idx < 18) ? mdl_r[idx] : 0;
`else
        return (idx >= 14 && idx <= 17) ? mdl_r[idx] : 0;
`endif
    endfunction

    function automatic void mdl_apply(input int a, input int d, input bit w, input bit r);
        int off;
        bit hit;
        hit = ((a >> 4) == 'h03B);
        off = a % 16;
        exp_sel = 0;
        if (hit && w) begin
            if (off < 8 && off % 2 == 0) mdl_idx = d % 32;
            else if (off < 8 && mdl_idx < 16) mdl_r[mdl_idx] = d % (1 << wid[mdl_idx]);
            else if (off == 8) mdl_mode = d;
        end else if (hit && r) begin
            exp_sel = 1;
            if (off < 8 && off % 2 == 1) exp_data = data_read(mdl_idx);
            else if (off == 10) exp_data = 'hF0 + cur_vs * 8 + cur_blank;
            else exp_data = 'hFF;
        end
    endfunction

    function automatic int exp_cursor_on();
        int fr;
        fr = mdl_frame % 32;
        case ((mdl_r[10] / 32) % 4)
            0: return 1;
            1: return 0;
            2: return (fr / 8) % 2;
            default: return (fr / 16) % 2;
        endcase
    endfunction

    task automatic chk_all(input string tag);
        check({tag, ".sel"},    32'(oIoSel),       32'(exp_sel));
        check({tag, ".data"},   32'(oIoData),      32'(exp_data));
        check({tag, ".start"},  32'(oStartAddr),   32'(mdl_r[12] * 256 + mdl_r[13]));
        check({tag, ".curs"},   32'(oCursorAddr),  32'(mdl_r[14] * 256 + mdl_r[15]));
        check({tag, ".cstart"}, 32'(oCursorStart), 32'(mdl_r[10] % 32));
        check({tag, ".cend"},   32'(oCursorEnd),   32'(mdl_r[11] % 32));
        check({tag, ".vid"},    32'(oVideoEn),     32'((mdl_mode / 8) % 2));
        check({tag, ".blinken"},32'(oBlinkEn),     32'((mdl_mode / 32) % 2));
        check({tag, ".curon"},  32'(oCursorOn),    32'(exp_cursor_on()));
        check({tag, ".cblink"}, 32'(oCharBlink),   32'(((mdl_frame % 32) / 16) % 2));
    endtask

    task automatic io(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        @(negedge iClk);
        iIoAddr = a; iIoData = d; iIoWr = w; iIoRd = r;
        @(negedge iClk);
        iIoWr = 1'b0; iIoRd = 1'b0;
        mdl_apply(int'(a), int'(d), w, r);
    endtask

    task automatic vs_pulse();
        @(negedge iClk);
        iVgaVs = 1'b1;
        repeat (4) @(negedge iClk);
        iVgaVs = 1'b0;
        repeat (4) @(negedge iClk);
        mdl_frame++;
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          op, toggles, prev_cb;

        iRstN = 1'b0; iIoAddr = 16'h0; iIoData = 8'h0; iIoWr = 1'b0; iIoRd = 1'b0;
        iVgaBlank = 1'b0; iVgaVs = 1'b0; cur_blank = 0; cur_vs = 0;
        mdl_reset();
        repeat (3) @(negedge iClk);
        chk_all("reset");
        iRstN = 1'b1;

        io(16'h03BA, 8'h00, 1'b0, 1'b1);
        check("status_f0", 32'(oIoData), 32'h0F0);
        chk_all("status");

        io(16'h03B4, 8'h0E, 1'b1, 1'b0);
        io(16'h03B5, 8'hFF, 1'b1, 1'b0);
        io(16'h03B4, 8'h0F, 1'b1, 1'b0);
        io(16'h03B5, 8'h34, 1'b1, 1'b0);
        check("cursor_3f34", 32'(oCursorAddr), 32'h3F34);
        io(16'h03B4, 8'h0E, 1'b1, 1'b0);
        io(16'h03B5, 8'h00, 1'b0, 1'b1);
        chk_all("r14_read");

        io(16'h03B4, 8'h0C, 1'b1, 1'b0);
        io(16'h03B5, 8'h12, 1'b1, 1'b0);
        io(16'h03B5, 8'h00, 1'b0, 1'b1);
        check("start_1200", 32'(oStartAddr), 32'h1200);
        chk_all("r12_read");

        io(16'h03B4, 8'h0A, 1'b1, 1'b0);
        io(16'h03B5, 8'h4B, 1'b1, 1'b0);
        chk_all("r10_write");
        toggles = 0;
        prev_cb = int'(oCharBlink);
        for (int p = 0; p < 32; p++) begin
            vs_pulse();
            chk_all("vs_pulse");
            if (int'(oCharBlink) != prev_cb) toggles++;
            prev_cb = int'(oCharBlink);
        end
        check("charblink_toggles", 32'(toggles), 32'd2);

        io(16'h03B8, 8'h28, 1'b1, 1'b0);
        io(16'h03B4, 8'h15, 1'b1, 1'b0);
        io(16'h03B5, 8'hAA, 1'b1, 1'b0);
        chk_all("idx21_write");
        io(16'h03BC, 8'h00, 1'b0, 1'b1);
        chk_all("read_3bc");
        io(16'h03D4, 8'h00, 1'b0, 1'b1);
        chk_all("miss_3d4");

        // Index write immediately followed by a data read must use the new index.
        @(negedge iClk);
        iIoAddr = 16'h03B2; iIoData = 8'h0F; iIoWr = 1'b1; iIoRd = 1'b0;
        @(negedge iClk);
        mdl_apply(16'h03B2, 8'h0F, 1'b1, 1'b0);
        iIoAddr = 16'h03B7; iIoWr = 1'b0; iIoRd = 1'b1;
        @(negedge iClk);
        iIoRd = 1'b0;
        mdl_apply(16'h03B7, 8'h00, 1'b0, 1'b1);
        chk_all("b2b_idx_read");

        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            d  = 8'($urandom);
            case (op)
                0, 1, 2: begin
                    d = {3'($urandom), 5'($urandom_range(0, 19))};
                    io({12'h03B, 3'($urandom_range(0, 3)), 1'b0}, d, 1'b1, 1'b0);
                end
                3, 4: io({12'h03B, 1'b0, 2'($urandom), 1'b1}, d, 1'b1, 1'($urandom_range(0, 3) == 0));
                5, 6: io({12'h03B, 1'b0, 2'($urandom), 1'b1}, d, 1'b0, 1'b1);
                7:    io(16'h03B8, d, 1'b1, 1'($urandom));
                8: begin
                    a = {12'h03B, 4'($urandom)};
                    if (a[3:0] == 4'hA) a[3:0] = 4'hB;
                    io(a, d, 1'($urandom), 1'($urandom));
                end
                default: begin
                    a = 16'($urandom);
                    if (a[15:4] == 12'h03B) a[15:4] = 12'h03D;
                    io(a, d, 1'($urandom), 1'($urandom));
                end
            endcase
            chk_all("rand");
        end

        for (int s = 0; s < 10; s++) begin
            @(negedge iClk);
            iVgaBlank = 1'($urandom);
            iVgaVs    = 1'($urandom);
            if (cur_vs == 0 && iVgaVs) mdl_frame++;
            cur_blank = int'(iVgaBlank);
            cur_vs    = int'(iVgaVs);
            repeat (4) @(negedge iClk);
            io(16'h03BA, 8'h00, 1'b0, 1'b1);
            chk_all("status_rand");
        end
        iVgaVs = 1'b0; iVgaBlank = 1'b0; cur_vs = 0; cur_blank = 0;
        repeat (4) @(negedge iClk);

        io(16'h03B4, 8'h0F, 1'b1, 1'b0);
        io(16'h03B5, 8'h77, 1'b1, 1'b0);
        @(negedge iClk);
        iIoAddr = 16'h03B5; iIoRd = 1'b1;
        @(posedge iClk);
        #2;
        iRstN = 1'b0;
        iIoRd = 1'b0;
        #1;
        mdl_reset();
        chk_all("async_reset");
        @(negedge iClk);
        iRstN = 1'b1;
        io(16'h03B5, 8'h00, 1'b0, 1'b0);
        chk_all("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mda_crtc_regs.md
# mda_crtc_regs

CPU-side register front end for the MDA text display: decodes the I/O window at 03B0h–03BFh and implements the MC6845 index/data register file, the mode-control latch (03B8h) and the status port (03BAh). It sits directly upstream of the MDA video generator and drives its start address, cursor geometry, cursor-on and blink controls. Retrace timing comes back from the 25 MHz video timing and is synchronised into this block's clock.

## Interface
- `IO_BASE`, 16'h03B0: base of the 16-byte I/O window; only addr[15:4] is compared.
- `iClk`  in  1  CPU-domain clock.
- `iRstN`  in  1  asynchronous, active-low reset.
- `iIoAddr`  in  16  I/O port address.
- `iIoData`  in  8  write data.
- `iIoWr`  in  1  single-cycle I/O write strobe.
- `iIoRd`  in  1  single-cycle I/O read strobe.
- `oIoData`  out  8  registered read data.
- `oIoSel`  out  1  registered: high for one cycle after a read hits the window.
- `iVgaBlank`  in  1  blanking, asynchronous (video domain).
- `iVgaVs`  in  1  vertical sync, active high, asynchronous.
- `oStartAddr`  out  14  {R12[5:0], R13}.
- `oCursorAddr`  out  14  {R14[5:0], R15}.
- `oCursorStart`  out  5  R10[4:0].
- `oCursorEnd`  out  5  R11[4:0].
- `oCursorOn`  out  1  cursor visible in the current blink phase.
- `oCharBlink`  out  1  attribute blink phase.
- `oVideoEn`  out  1  mode bit 3.
- `oBlinkEn`  out  1  mode bit 5.

## Operation
- Hit: `iIoAddr[15:4] == IO_BASE[15:4]`. Offset is `iIoAddr[3:0]`.
- Offsets 0, 2, 4, 6 (even, 0–7): index register.
  - A write stores `iIoData[4:0]`.
  - A read returns 0xFF.
- Offsets 1, 3, 5, 7 (odd, 0–7): data register.
  - A write updates R[index], with the data masked to the register's width.
  - Writes to index > 17 are ignored.
  - Writes to R16 and R17 are ignored.
- Register widths: R0–R3 8; R4 7; R5 5; R6 7; R7 7; R8 2; R9 5; R10 7; R11 5; R12 6; R13 8; R14 6; R15 8; R16 6; R17 8.
- Reset values: R0=61h, R1=50h, R2=52h, R3=0Fh, R4=19h, R5=06h, R6=19h, R7=19h, R8=02h, R9=0Dh, R10=0Bh, R11=0Ch. All others are 0.
- Data-port read:
  - R14–R17 return the stored value (R16 and R17 are always 0; there is no light pen).
  - Every other index returns 00h (see Configuration).
- Offset 8: mode control.
  - A write stores `iIoData` into the mode register.
  - A read returns 0xFF.
- Offset A: status, read only.
  - Value is {4'b1111, syncVs, 2'b00, syncBlank}.
  - Reading has no side effects.
- Offsets 9, B–F: writes are ignored; reads return 0xFF.
- Synchroniser: `iVgaBlank` and `iVgaVs` each pass through a 2-FF synchroniser to give syncBlank and syncVs.
- Frame counter:
  - 5-bit `frameCnt` increments on each rising edge of syncVs (detected one cycle after syncVs rises).
  - It wraps 31→0.
- Cursor blink mode is R10[6:5]:
  - 00: oCursorOn=1.
  - 01: oCursorOn=0.
  - 10: oCursorOn=frameCnt[3].
  - 11: oCursorOn=frameCnt[4].
- `oCharBlink` = frameCnt[4].
- `iIoRd` and `iIoWr` in the same cycle: the write is performed, and `oIoData` and `oIoSel` are unchanged and low respectively.

## Timing
- Reset state:
  - Index is 0, mode is 00h, frameCnt is 0, synchroniser flops are 0.
  - `oIoData`=00h, `oIoSel`=0.
  - `oStartAddr`=0, `oCursorAddr`=0, `oCursorStart`=0Bh, `oCursorEnd`=0Ch.
  - `oCursorOn`=1, `oCharBlink`=0, `oVideoEn`=0, `oBlinkEn`=0.
- Writes take effect at the strobe edge; register outputs change one cycle later.
- Reads: `oIoData` and `oIoSel` are valid in the cycle after `iIoRd`.
  - `oIoData` holds its last value otherwise.
  - `oIoSel` stays low for a miss.
- Back-to-back strobes are supported at one per cycle.
  - A data read immediately after an index write uses the new index.
- Status latency: 2–3 cycles from an `iVgaBlank`/`iVgaVs` change to the status bit.
  - frameCnt increments 3 cycles after `iVgaVs` rises.
- Reset asserted mid-operation clears everything immediately, including an in-flight read result.

## Configuration
- `MDA_CRTC_FULL_READBACK_EN`
  - Defined: data reads at indices 0–17 return the stored masked value; index > 17 returns 00h.
  - Undefined: only R14–R17 are readable, as on a stock 6845; all other indices return 00h.
- Write behaviour is identical either way.

## Test plan
- Reset, then read 03BAh with `iVgaBlank`=0 and `iVgaVs`=0 → `oIoData`=F0h and `oIoSel`=1 in the next cycle.
- Write 03B4h←0Eh, 03B5h←FFh, 03B4h←0Fh, 03B5h←34h → `oCursorAddr`=3F34h.
  - Then write 03B4h←0Eh and read 03B5h → 3Fh.
- Write 03B4h←0Ch, 03B5h←12h, then read 03B5h → 00h without the macro, 12h with it.
  - In both cases `oStartAddr`=1200h.
- Write R10←4Bh (blink /16), then apply 16 `iVgaVs` pulses → `oCursorOn` is 0 for frameCnt 0–7 and 1 for frameCnt 8–15.
  - After 32 pulses, `oCharBlink` has toggled twice.
- Write 03B8h←28h → `oVideoEn`=1, `oBlinkEn`=1. Write 03B4h←15h then 03B5h←AAh → no register changes.
  - A read of 03BCh returns FFh.
  - `iIoAddr`=03D4h produces `oIoSel`=0.
- Assert `iRstN` low mid-sequence after a cursor write → all outputs return to their reset values asynchronously.
